multicycle_ctrl: RTL and testbench

Moore/Mealy control FSM that sequences the shared multicycle RV32I datapath: PC register, instruction register, unified memory port, register file, ALU and the immediate extender. It decodes the opcode latched in the instruction register and drives every datapath select and strobe, including the 2-bit immediate-format select consumed by the extender. It stalls on a memory ready handshake and halts on unsupported instructions.

---
 rtl/multicycle_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared multicycle RV32I datapath (fetch, decode, execute, writeback).
// Define MULTICYCLE_CTRL_PERF_EN to add the CycleCount/InstrCount performance counters.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       Illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] CycleCount,
    output logic [31:0] InstrCount
`endif
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_LUI,
        S_BRANCH,
        S_HALT
    } state_t;

    state_t state_q, state_d;

    // funct3 encodings with no ALU operation behind them (shifts, sltu) send the FSM to HALT.
    logic aluFunctBad;
    assign aluFunctBad = (funct3 == 3'b001) || (funct3 == 3'b011) || (funct3 == 3'b101);

    function automatic logic [2:0] aluDecode(input logic [2:0] f3, input logic subEn);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = subEn ? 3'b001 : 3'b000;
            3'b010:  ctl = 3'b101;
            3'b100:  ctl = 3'b100;
            3'b110:  ctl = 3'b011;
            3'b111:  ctl = 3'b010;
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemRead    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        ALUControl = 3'b000;
        ResultSrc  = 2'd0;
        ImmSrc     = 2'd0;
        Illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = 2'd2;
                    ResultSrc = 2'd2;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd1;
                ImmSrc  = (op == 7'b1101111) ? 2'd1 : 2'd3;
                case (op)
                    7'b0000011: state_d = S_MEMADR;
                    7'b0110011: state_d = aluFunctBad ? S_HALT : S_EXECR;
                    7'b0010011: state_d = aluFunctBad ? S_HALT : S_EXECI;
                    7'b1101111: state_d = S_JAL;
                    7'b0110111: state_d = S_LUI;
                    7'b1100011: state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_HALT;
                    default:    state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd1;
                state_d = S_MEMREAD;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc = 2'd1;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'd2;
                ALUControl = aluDecode(funct3, funct7b5);
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'd2;
                ALUSrcB    = 2'd1;
                ALUControl = aluDecode(funct3, 1'b0);
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ImmSrc    = 2'd2;
                ResultSrc = 2'd3;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'd2;
                ALUControl = 3'b001;
                PCWrite    = zero ^ funct3[0];
                state_d    = S_FETCH;
            end
            S_HALT: begin
                Illegal = 1'b1;
            end
            default: state_d = S_HALT;
        endcase

        // Reset must not let the FETCH strobes reach the datapath.
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemRead  = 1'b0;
            Illegal  = 1'b0;
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycleCount_q, cycleCount_d;
    logic [31:0] instrCount_q, instrCount_d;
    logic        instrDone;

    assign instrDone = (state_d == S_FETCH) &&
                       ((state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                        (state_q == S_LUI)   || (state_q == S_BRANCH));

    always_comb begin
        cycleCount_d = cycleCount_q;
        instrCount_d = instrCount_q;
        if (state_q != S_HALT) begin
            cycleCount_d = cycleCount_q + 32'd1;
        end
        if (instrDone) begin
            instrCount_d = instrCount_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycleCount_q <= 32'd0;
            instrCount_q <= 32'd0;
        end else begin
            cycleCount_q <= cycleCount_d;
            instrCount_q <= instrCount_d;
        end
    end

    assign CycleCount = cycleCount_q;
    assign InstrCount = instrCount_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks each instruction class cycle by cycle
// and compares every control output against hand-derived per-state vectors.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemRead, IRWrite, RegWrite, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] CycleCount, InstrCount;
`endif

    int total = 0;
    int bad   = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemRead    (MemRead),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .Illegal    (Illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .CycleCount (CycleCount),
        .InstrCount (InstrCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {PCWrite,AdrSrc,MemRead,IRWrite,RegWrite,ALUSrcA,ALUSrcB,ALUControl,ResultSrc,ImmSrc,Illegal}
    logic [16:0] obs;
    assign obs = {PCWrite, AdrSrc, MemRead, IRWrite, RegWrite, ALUSrcA, ALUSrcB,
                  ALUControl, ResultSrc, ImmSrc, Illegal};

    localparam logic [16:0] V_IDLE       = 17'b0;
    localparam logic [16:0] V_FETCH_WAIT = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] V_FETCH_GO   = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 3'd0, 2'd2, 2'd0, 1'b0};
    localparam logic [16:0] V_DECODE     = {5'b0, 2'd1, 2'd1, 3'd0, 2'd0, 2'd3, 1'b0};
    localparam logic [16:0] V_DECODE_J   = {5'b0, 2'd1, 2'd1, 3'd0, 2'd0, 2'd1, 1'b0};
    localparam logic [16:0] V_MEMADR     = {5'b0, 2'd2, 2'd1, 3'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] V_MEMREAD    = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'b0};
    localparam logic [16:0] V_MEMWB      = {4'b0, 1'b1, 2'd0, 2'd0, 3'd0, 2'd1, 2'd0, 1'b0};
    localparam logic [16:0] V_EXECR      = {5'b0, 2'd2, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] V_EXECI      = {5'b0, 2'd2, 2'd1, 3'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] V_ALUWB      = {4'b0, 1'b1, 12'b0};
    localparam logic [16:0] V_JAL        = {1'b1, 4'b0, 2'd1, 2'd2, 3'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] V_LUI        = {4'b0, 1'b1, 2'd0, 2'd0, 3'd0, 2'd3, 2'd2, 1'b0};
    localparam logic [16:0] V_BRANCH     = {5'b0, 2'd2, 2'd0, 3'd1, 2'd0, 2'd0, 1'b0};
    localparam logic [16:0] V_HALT       = {16'b0, 1'b1};

    // Leaves the bench on a falling edge with rst released and the FSM in FETCH.
    task automatic doReset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0;
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        #1;
        total++;
        if (obs !== V_IDLE) begin
            bad++;
            $display("FAIL reset_idle got=%05h want=%05h", obs, V_IDLE);
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if ({obs[16], obs[14:12], obs[0]} !== 5'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%05h want strobes 0", obs);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (obs !== V_FETCH_WAIT) begin
            bad++;
            $display("FAIL reset_first_fetch got=%05h want=%05h", obs, V_FETCH_WAIT);
        end
        @(negedge clk);
    endtask

    task automatic test_addi();
        logic [16:0] want [5];
        want = '{V_FETCH_GO, V_DECODE, V_EXECI, V_ALUWB, V_FETCH_GO};
        doReset();
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            #1;
            total++;
            if (obs !== want[i]) begin
                bad++;
                $display("FAIL addi[%0d] got=%05h want=%05h", i, obs, want[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        logic [16:0] want [10];
        logic        rdy  [10];
        want = '{V_FETCH_WAIT, V_FETCH_GO, V_DECODE, V_MEMADR, V_MEMREAD,
                 V_MEMREAD, V_MEMREAD, V_MEMREAD, V_MEMWB, V_FETCH_WAIT};
        rdy  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        doReset();
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if (obs !== want[i]) begin
                bad++;
                $display("FAIL load[%0d] got=%05h want=%05h", i, obs, want[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3s [4];
        logic       zs  [4];
        logic       pcw [4];
        logic [16:0] want [4];
        f3s = '{3'b001, 3'b001, 3'b000, 3'b000};
        zs  = '{1'b0, 1'b1, 1'b1, 1'b0};
        pcw = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 4; c++) begin
            doReset();
            op = 7'b1100011; funct3 = f3s[c]; funct7b5 = 1'b0;
            zero = zs[c];
            want = '{V_FETCH_GO, V_DECODE, V_BRANCH | {pcw[c], 16'b0}, V_FETCH_GO};
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'b1;
                #1;
                total++;
                if (obs !== want[i]) begin
                    bad++;
                    $display("FAIL branch%0d[%0d] got=%05h want=%05h", c, i, obs, want[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_alu_ops();
        logic       isImm [9];
        logic [2:0] f3s   [9];
        logic       f7s   [9];
        logic [2:0] alus  [9];
        logic [16:0] want [4];
        isImm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        f3s   = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b110, 3'b111, 3'b000, 3'b010, 3'b110};
        f7s   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        alus  = '{3'b001, 3'b000, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000, 3'b101, 3'b011};
        for (int c = 0; c < 9; c++) begin
            doReset();
            op = isImm[c] ? 7'b0010011 : 7'b0110011;
            funct3 = f3s[c]; funct7b5 = f7s[c];
            want = '{V_FETCH_GO, V_DECODE,
                     (isImm[c] ? V_EXECI : V_EXECR) | {9'b0, alus[c], 5'b0}, V_ALUWB};
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'b1;
                #1;
                total++;
                if (obs !== want[i]) begin
                    bad++;
                    $display("FAIL alu%0d[%0d] got=%05h want=%05h", c, i, obs, want[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_jal_lui();
        logic [16:0] wantJ [5];
        logic [16:0] wantL [4];
        wantJ = '{V_FETCH_GO, V_DECODE_J, V_JAL, V_ALUWB, V_FETCH_GO};
        wantL = '{V_FETCH_GO, V_DECODE, V_LUI, V_FETCH_GO};
        doReset();
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            #1;
            total++;
            if (obs !== wantJ[i]) begin
                bad++;
                $display("FAIL jal[%0d] got=%05h want=%05h", i, obs, wantJ[i]);
            end
            @(negedge clk);
        end
        doReset();
        op = 7'b0110111; funct3 = 3'b101;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            total++;
            if (obs !== wantL[i]) begin
                bad++;
                $display("FAIL lui[%0d] got=%05h want=%05h", i, obs, wantL[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        logic [6:0] ops [5];
        logic [2:0] f3s [5];
        ops = '{7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b0000000};
        f3s = '{3'b010, 3'b001, 3'b101, 3'b100, 3'b000};
        for (int c = 0; c < 5; c++) begin
            doReset();
            op = ops[c]; funct3 = f3s[c]; funct7b5 = 1'b0;
            for (int i = 0; i < 12; i++) begin
                mem_ready = (i < 2) ? 1'b1 : i[0];
                zero = i[1];
                #1;
                total++;
                if (obs !== ((i == 0) ? V_FETCH_GO : (i == 1) ? V_DECODE : V_HALT)) begin
                    bad++;
                    $display("FAIL halt%0d[%0d] got=%05h", c, i, obs);
                end
                @(negedge clk);
            end
            mem_ready = 1'b0;
            rst = 1'b1;
            #1;
            total++;
            if (obs !== V_IDLE) begin
                bad++;
                $display("FAIL halt%0d_rst got=%05h want=%05h", c, obs, V_IDLE);
            end
            @(negedge clk);
            rst = 1'b0;
            #1;
            total++;
            if (obs !== V_FETCH_WAIT) begin
                bad++;
                $display("FAIL halt%0d_refetch got=%05h want=%05h", c, obs, V_FETCH_WAIT);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midwait();
        logic [16:0] want [5];
        logic        rdy  [5];
        want = '{V_FETCH_GO, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMREAD};
        rdy  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        doReset();
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if (obs !== want[i]) begin
                bad++;
                $display("FAIL midwait[%0d] got=%05h want=%05h", i, obs, want[i]);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({obs[16], obs[14:12], obs[0]} !== 5'b0) begin
            bad++;
            $display("FAIL midwait_rst got=%05h want strobes 0", obs);
        end
        @(posedge clk);
        #1;
        total++;
        if ({obs[16], obs[14:12], obs[0]} !== 5'b0) begin
            bad++;
            $display("FAIL midwait_rst_hold got=%05h want strobes 0", obs);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (obs !== V_FETCH_WAIT) begin
            bad++;
            $display("FAIL midwait_refetch got=%05h want=%05h", obs, V_FETCH_WAIT);
        end
        @(negedge clk);
    endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
    task automatic test_perf();
        doReset();
        funct3 = 3'b000; funct7b5 = 1'b0;
        total++;
        if (CycleCount !== 32'd0 || InstrCount !== 32'd0) begin
            bad++;
            $display("FAIL perf_reset got cyc=%0d ins=%0d want 0/0", CycleCount, InstrCount);
        end
        for (int i = 0; i < 18; i++) begin
            op = (i < 8) ? 7'b0010011 : (i < 11) ? 7'b0110111 : 7'b0100011;
            mem_ready = 1'b1;
            #1;
            if (i == 4) begin
                total++;
                if (CycleCount !== 32'd4 || InstrCount !== 32'd1) begin
                    bad++;
                    $display("FAIL perf_mid got cyc=%0d ins=%0d want 4/1", CycleCount, InstrCount);
                end
            end
            if (i == 11) begin
                total++;
                if (CycleCount !== 32'd11 || InstrCount !== 32'd3 || obs !== V_FETCH_GO) begin
                    bad++;
                    $display("FAIL perf_fetch4 got cyc=%0d ins=%0d obs=%05h want 11/3", CycleCount, InstrCount, obs);
                end
            end
            @(negedge clk);
        end
        total++;
        if (CycleCount !== 32'd13 || InstrCount !== 32'd3 || obs !== V_HALT) begin
            bad++;
            $display("FAIL perf_halt got cyc=%0d ins=%0d obs=%05h want 13/3", CycleCount, InstrCount, obs);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_addi();
        test_load();
        test_branch();
        test_alu_ops();
        test_jal_lui();
        test_halt();
        test_reset_midwait();
`ifdef MULTICYCLE_CTRL_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
